adv7513_config_seq: RTL
=======================

ADV7513_CONFIG_SEQ -- requirements
Module: adv7513_config_seq

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h39, meaning 7-bit I2C address of ADV7513 main map (0x72 write).
REQ-002 SHALL have parameter TICKS_PER_MS, default 74250, meaning clk cycles per 1 ms delay unit.
REQ-003 SHALL have parameter MAX_RETRIES, default 3, meaning extra attempts per entry after an I2C error.
REQ-004 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: start  in  1  one-cycle pulse that starts the sequence; hpd  in  1  asynchronous hot-plug detect.
REQ-006 SHALL have ports: rom_addr  out  8  config ROM address; rom_data  in  16  ROM word {reg[15:8], val[7:0]}, registered ROM.
REQ-007 SHALL have ports: i2c_req  out  1; i2c_dev  out  7; i2c_reg  out  8; i2c_val  out  8; i2c_ack  in  1  one-cycle completion pulse; i2c_err  in  1  NACK flag, valid only with i2c_ack.
REQ-008 SHALL have ports: busy  out  1; done  out  1  sticky success; error  out  1  sticky failure.

Function
REQ-009 SHALL implement states IDLE, FETCH, WAIT, DECODE, WRITE, DELAY, DONE, FAIL.
REQ-010 SHALL go IDLE/DONE/FAIL -> FETCH on start, with rom_addr=0, retry count=0, done=0, error=0.
REQ-011 SHALL ignore start while busy (any state other than IDLE/DONE/FAIL).
REQ-012 SHALL go FETCH -> WAIT -> DECODE, sampling rom_data in DECODE exactly 2 cycles after rom_addr changes.
REQ-013 SHALL in DECODE: 16'hFFFF -> DONE; rom_data[15:8]==8'hFE -> DELAY for rom_data[7:0] ms; otherwise -> WRITE.
REQ-014 SHALL in WRITE hold i2c_req=1 with i2c_dev=DEV_ADDR and i2c_reg/i2c_val stable until the cycle i2c_ack=1, then drop i2c_req on the following edge.
REQ-015 SHALL on ack with i2c_err=0 advance the entry; on ack with i2c_err=1 re-issue the same entry if retries<MAX_RETRIES, else go FAIL.
REQ-016 SHALL advance entry as: rom_addr==8'hFF -> DONE (no wrap); else rom_addr+1, retry count=0, -> FETCH.
REQ-017 SHALL treat a delay of 0 ms as zero wait (DELAY exits next cycle); delay of N ms SHALL last N*TICKS_PER_MS cycles (+/-1).
REQ-018 SHALL drive busy=1 in FETCH/WAIT/DECODE/WRITE/DELAY; done=1 only in DONE; error=1 only in FAIL.
REQ-019 SHALL ignore i2c_ack outside WRITE.

Reset
REQ-020 SHALL on reset force IDLE, rom_addr=0, i2c_req=0, i2c_reg=0, i2c_val=0, busy=0, done=0, error=0, timers cleared.
REQ-021 SHALL on reset mid-WRITE drop i2c_req at the reset edge, not waiting for ack.

Configuration
REQ-022 SHALL honour macro ADV7513_HPD_RESTART_EN: when defined, hpd passes a 2-flop synchronizer and a rising edge restarts the sequence from rom_addr 0 as if start.
REQ-023 SHALL with ADV7513_HPD_RESTART_EN, on an hpd rise during WRITE, finish the in-flight transaction (wait ack) before restarting; in other busy states restart immediately.
REQ-024 SHALL without ADV7513_HPD_RESTART_EN ignore hpd entirely (port kept, no synchronizer logic).

Structure
REQ-025 SHALL place state enum, END_ENTRY=16'hFFFF and DELAY_OPCODE=8'hFE in shared package adv7513_pkg.
REQ-026 SHALL implement the delay as sub-module adv7513_ms_timer (load N, TICKS_PER_MS prescaler, expired pulse).

Verification
REQ-027 SHALL test ROM {16'h4110, 16'hFFFF}, start, ack with err=0 -> one write reg=0x41 val=0x10 dev=0x39, then done=1, busy=0.
REQ-028 SHALL test ROM {16'hFE02, 16'hFFFF}, TICKS_PER_MS=10 -> no i2c_req, done asserts ~20 cycles after DECODE.
REQ-029 SHALL test entry 16'h9803 with err=1 on 4 consecutive acks (MAX_RETRIES=3) -> exactly 4 requests, then error=1, done=0.
REQ-030 SHALL test ROM with 256 non-end entries -> 256 writes, done after addr 0xFF, rom_addr not wrapping to 0.
REQ-031 SHALL test reset asserted while i2c_req=1 -> i2c_req=0 next cycle, all outputs at reset values.
REQ-032 SHALL test with ADV7513_HPD_RESTART_EN, hpd rise in DONE -> sequence reruns from rom_addr 0; without macro -> no activity.

Source files
------------

// File: rtl/adv7513_pkg.sv
// Shared definitions for the ADV7513 configuration sequencer.
// Holds the sequencer state encoding, the internal action codes passed from
// next-state logic to the datapath, and the special ROM word values.
package adv7513_pkg;

    localparam int unsigned ROM_AW    = 8;
    localparam int unsigned ROM_DW    = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned I2C_DEV_W = 7;

    // ROM word that terminates the table
    localparam logic [ROM_DW-1:0] END_ENTRY    = 16'hFFFF;
    // Register byte that marks a delay entry; value byte is the delay in ms
    localparam logic [BYTE_W-1:0] DELAY_OPCODE = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        WRITE,
        DELAY,
        DONE,
        FAIL
    } state_t;

    // What the datapath does to rom_addr / retry count on a transition
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_RESTART,
        ACT_ADVANCE,
        ACT_RETRY
    } action_t;

endpackage

// File: rtl/adv7513_ms_timer.sv
// Millisecond delay timer for the ADV7513 sequencer.
// load   : captures ms and starts counting (prescaled by TICKS_PER_MS)
// ms     : delay length in milliseconds
// expired_c : high while a loaded delay has fully elapsed; a 0 ms load
//             reports expiry in the first cycle after the load.
module adv7513_ms_timer #(
    parameter int unsigned TICKS_PER_MS = 74250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] ms,
    output logic       expired_c
);

    localparam int unsigned TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic [7:0]        ms_left;
    logic              active;

    assign expired_c = active && (ms_left == 8'd0);

    // Prescaler counts TICKS_PER_MS cycles per remaining millisecond
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            ms_left  <= '0;
            active   <= 1'b0;
        end else if (load) begin
            tick_cnt <= '0;
            ms_left  <= ms;
            active   <= 1'b1;
        end else if (active) begin
            if (ms_left == 8'd0) begin
                active <= 1'b0;
            end else if (tick_cnt == TICK_W'(TICKS_PER_MS - 1)) begin
                tick_cnt <= '0;
                ms_left  <= ms_left - 8'd1;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/adv7513_config_seq.sv
// ADV7513 register configuration sequencer.
// Walks a registered config ROM of {reg, val} words from address 0, issuing
// one I2C register write per entry, honouring delay entries (reg == 0xFE) and
// stopping at the 0xFFFF end marker or after address 0xFF.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : one-cycle pulse, (re)starts when not busy
//   hpd                   : hot-plug detect (asynchronous)
//   rom_addr / rom_data   : config ROM interface, one cycle read latency
//   i2c_req/dev/reg/val   : write request to the I2C master, held until ack
//   i2c_ack / i2c_err     : completion pulse and NACK flag
//   busy / done / error   : status; done and error are sticky until restart
// Build option: define ADV7513_HPD_RESTART_EN to make a rising hpd edge
// restart the sequence (a write in flight is allowed to complete first).
module adv7513_config_seq
    import adv7513_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR     = 7'h39,
    parameter int unsigned TICKS_PER_MS = 74250,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 hpd,
    output logic [ROM_AW-1:0]    rom_addr,
    input  logic [ROM_DW-1:0]    rom_data,
    output logic                 i2c_req,
    output logic [I2C_DEV_W-1:0] i2c_dev,
    output logic [BYTE_W-1:0]    i2c_reg,
    output logic [BYTE_W-1:0]    i2c_val,
    input  logic                 i2c_ack,
    input  logic                 i2c_err,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    state_t              state;
    state_t              next_state;
    action_t             action;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [RETRY_W-1:0]  retry_d;
    logic [ROM_AW-1:0]   rom_addr_d;
    logic                req_d;
    logic                busy_d;
    logic                done_d;
    logic                error_d;
    logic                latch_cmd_c;
    logic                timer_load_c;
    logic                timer_expired_c;
    logic                hpd_rise_c;
    logic                restart_pend;
    logic                is_end_c;
    logic                is_delay_c;
    logic                last_addr_c;
    logic                retry_ok_c;

    assign i2c_dev     = DEV_ADDR;
    assign is_end_c    = (rom_data == END_ENTRY);
    assign is_delay_c  = (rom_data[15:8] == DELAY_OPCODE);
    assign last_addr_c = (rom_addr == ROM_AW'(8'hFF));
    assign retry_ok_c  = (retry_cnt < RETRY_W'(MAX_RETRIES));

`ifdef ADV7513_HPD_RESTART_EN
    logic [2:0] hpd_sync;

    // Two synchronizer flops plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            hpd_sync <= '0;
        end else begin
            hpd_sync <= {hpd_sync[1:0], hpd};
        end
    end

    assign hpd_rise_c = hpd_sync[1] & ~hpd_sync[2];

    // Remembers an hpd rise seen mid-write so the restart happens at ack
    always_ff @(posedge clk) begin
        if (reset) begin
            restart_pend <= 1'b0;
        end else if (action == ACT_RESTART) begin
            restart_pend <= 1'b0;
        end else if (state == WRITE && hpd_rise_c) begin
            restart_pend <= 1'b1;
        end
    end
`else
    logic unused_hpd;
    assign unused_hpd   = hpd;
    assign hpd_rise_c   = 1'b0;
    assign restart_pend = 1'b0;
`endif

    adv7513_ms_timer #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_ms_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load_c),
        .ms        (rom_data[7:0]),
        .expired_c (timer_expired_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the rom_addr/retry action for the transition
    always_comb begin
        next_state = state;
        action     = ACT_NONE;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start || hpd_rise_c) begin
                    next_state = FETCH;
                    action     = ACT_RESTART;
                end
            end
            FETCH: begin
                if (hpd_rise_c) begin
                    next_state = FETCH;
                    action     = ACT_RESTART;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (hpd_rise_c) begin
                    next_state = FETCH;
                    action     = ACT_RESTART;
                end else begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (hpd_rise_c) begin
                    next_state = FETCH;
                    action     = ACT_RESTART;
                end else if (is_end_c) begin
                    next_state = DONE;
                end else if (is_delay_c) begin
                    next_state = DELAY;
                end else begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (i2c_ack) begin
                    if (hpd_rise_c || restart_pend) begin
                        next_state = FETCH;
                        action     = ACT_RESTART;
                    end else if (!i2c_err) begin
                        next_state = last_addr_c ? DONE : FETCH;
                        action     = ACT_ADVANCE;
                    end else if (retry_ok_c) begin
                        next_state = FETCH;
                        action     = ACT_RETRY;
                    end else begin
                        next_state = FAIL;
                    end
                end
            end
            DELAY: begin
                if (hpd_rise_c) begin
                    next_state = FETCH;
                    action     = ACT_RESTART;
                end else if (timer_expired_c) begin
                    next_state = last_addr_c ? DONE : FETCH;
                    action     = ACT_ADVANCE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        rom_addr_d   = rom_addr;
        retry_d      = retry_cnt;
        req_d        = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        latch_cmd_c  = 1'b0;
        timer_load_c = 1'b0;
        case (action)
            ACT_RESTART: begin
                rom_addr_d = '0;
                retry_d    = '0;
            end
            ACT_ADVANCE: begin
                // Address 0xFF is the last entry; never wrap back to 0
                if (!last_addr_c) begin
                    rom_addr_d = rom_addr + ROM_AW'(1);
                end
                retry_d = '0;
            end
            ACT_RETRY: begin
                retry_d = retry_cnt + RETRY_W'(1);
            end
            default: begin
            end
        endcase
        req_d   = (next_state == WRITE);
        busy_d  = (next_state == FETCH) || (next_state == WAIT) || (next_state == DECODE) ||
                  (next_state == WRITE) || (next_state == DELAY);
        done_d  = (next_state == DONE);
        error_d = (next_state == FAIL);
        latch_cmd_c  = (state == DECODE) && (next_state == WRITE);
        timer_load_c = (state == DECODE) && (next_state == DELAY);
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr  <= '0;
            retry_cnt <= '0;
            i2c_req   <= 1'b0;
            i2c_reg   <= '0;
            i2c_val   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rom_addr  <= rom_addr_d;
            retry_cnt <= retry_d;
            i2c_req   <= req_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            if (latch_cmd_c) begin
                i2c_reg <= rom_data[15:8];
                i2c_val <= rom_data[7:0];
            end
        end
    end

endmodule
